// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller for a 5-stage in-order core. Each cycle it picks
// exactly one condition with fixed priority FREEZE > FLUSH > STALL > RUN and
// drives the pipeline enables for it combinationally. The chosen condition is
// also registered onto state_o and counted in saturating event counters.
//
// Ports
//   clk                 pipeline clock, rising edge
//   reset               asynchronous active-low reset (0 = in reset)
//   IF_ID_rs1_i/rs2_i   source register fields of the instruction in IF/ID
//   ID_EX_rd_i          destination register held in ID/EX
//   ID_EX_mem_read_i    ID/EX holds a load
//   redirect_i          taken branch / jalr resolved in EX this cycle
//   mem_busy_i          data memory not ready, whole pipeline holds
//   pc_write_o          PC update enable
//   IF_ID_write_o       IF/ID load enable
//   IF_ID_flush_o       IF/ID clears to a NOP
//   ID_EX_write_o       ID/EX load enable
//   ID_EX_bubble_o      ID/EX loads all-zero control
//   state_o             registered condition: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
//   stall_count_o,
//   flush_count_o,
//   freeze_count_o      saturating per-condition cycle counters
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1_i,
    input  logic [4:0]       IF_ID_rs2_i,
    input  logic [4:0]       ID_EX_rd_i,
    input  logic             ID_EX_mem_read_i,
    input  logic             redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_write_o,
    output logic             ID_EX_bubble_o,
    output logic [1:0]       state_o,
    output logic [NBits-1:0] stall_count_o,
    output logic [NBits-1:0] flush_count_o,
    output logic [NBits-1:0] freeze_count_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_FREEZE = 2'd3;

    logic [1:0] state_q;
    logic [1:0] cond;
    logic       pending_redirect_q;
    logic       load_use;

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign load_use = ID_EX_mem_read_i && (ID_EX_rd_i != 5'd0) &&
                      ((ID_EX_rd_i == IF_ID_rs1_i) || (ID_EX_rd_i == IF_ID_rs2_i));

    // Next-state: the condition selected for the current cycle.
    // A redirect seen while frozen is remembered and replayed as a FLUSH once
    // memory releases the pipeline. FLUSH outranks STALL because the
    // instruction that would have stalled is being discarded anyway.
    always_comb begin
        cond = ST_RUN;
        if (mem_busy_i) begin
            cond = ST_FREEZE;
        end else if (redirect_i || pending_redirect_q) begin
            cond = ST_FLUSH;
        end else if (load_use) begin
            cond = ST_STALL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= cond;
        end
    end

    assign state_o = state_q;

    // Redirect remembered across any number of FREEZE cycles; cleared by the
    // single FLUSH cycle that consumes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_redirect_q <= 1'b0;
        end else if (cond == ST_FREEZE) begin
            if (redirect_i) begin
                pending_redirect_q <= 1'b1;
            end
        end else if (cond == ST_FLUSH) begin
            pending_redirect_q <= 1'b0;
        end
    end

    // Outputs from the current-cycle condition. Everything is held low while
    // reset is asserted so nothing in the pipeline moves during reset.
    always_comb begin
        pc_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_write_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        if (reset) begin
            case (cond)
                ST_RUN: begin
                    pc_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                    ID_EX_write_o = 1'b1;
                end
                ST_STALL: begin
                    ID_EX_write_o  = 1'b1;
                    ID_EX_bubble_o = 1'b1;
                end
                ST_FLUSH: begin
                    pc_write_o     = 1'b1;
                    IF_ID_write_o  = 1'b1;
                    IF_ID_flush_o  = 1'b1;
                    ID_EX_write_o  = 1'b1;
                    ID_EX_bubble_o = 1'b1;
                end
                default: begin
                    // FREEZE: all enables stay low.
                end
            endcase
        end
    end

    // Saturating event counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_o  <= '0;
            flush_count_o  <= '0;
            freeze_count_o <= '0;
        end else begin
            if ((cond == ST_STALL) && (stall_count_o != '1)) begin
                stall_count_o <= stall_count_o + NBits'(1);
            end
            if ((cond == ST_FLUSH) && (flush_count_o != '1)) begin
                flush_count_o <= flush_count_o + NBits'(1);
            end
            if ((cond == ST_FREEZE) && (freeze_count_o != '1)) begin
                freeze_count_o <= freeze_count_o + NBits'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed bench for hazard_control_unit. Two instances share all inputs: the
// default 32-bit counter build and a 4-bit counter build for saturation.
// Inputs are driven 1 time unit after a rising edge; the combinational enables
// are sampled on the falling edge, registered state/counters 1 unit after the
// next rising edge.
//
// Enable vector packing: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
// ID_EX_bubble}.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam logic [4:0] O_RUN    = 5'b11010;
    localparam logic [4:0] O_STALL  = 5'b00011;
    localparam logic [4:0] O_FLUSH  = 5'b11111;
    localparam logic [4:0] O_FREEZE = 5'b00000;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_STALL  = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_FREEZE = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, redirect, mem_busy;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_bubble4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4, freeze_cnt4;

    logic [4:0]  outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble};

    hazard_control_unit #(.NBits(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_rs1_i      (rs1),
        .IF_ID_rs2_i      (rs2),
        .ID_EX_rd_i       (rd),
        .ID_EX_mem_read_i (mem_read),
        .redirect_i       (redirect),
        .mem_busy_i       (mem_busy),
        .pc_write_o       (pc_write),
        .IF_ID_write_o    (if_id_write),
        .IF_ID_flush_o    (if_id_flush),
        .ID_EX_write_o    (id_ex_write),
        .ID_EX_bubble_o   (id_ex_bubble),
        .state_o          (state),
        .stall_count_o    (stall_cnt),
        .flush_count_o    (flush_cnt),
        .freeze_count_o   (freeze_cnt)
    );

    hazard_control_unit #(.NBits(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_rs1_i      (rs1),
        .IF_ID_rs2_i      (rs2),
        .ID_EX_rd_i       (rd),
        .ID_EX_mem_read_i (mem_read),
        .redirect_i       (redirect),
        .mem_busy_i       (mem_busy),
        .pc_write_o       (pc_write4),
        .IF_ID_write_o    (if_id_write4),
        .IF_ID_flush_o    (if_id_flush4),
        .ID_EX_write_o    (id_ex_write4),
        .ID_EX_bubble_o   (id_ex_bubble4),
        .state_o          (state4),
        .stall_count_o    (stall_cnt4),
        .flush_count_o    (flush_cnt4),
        .freeze_count_o   (freeze_cnt4)
    );

    // ---------------- scoreboard ----------------
    int total_checks = 0;
    int bad_checks   = 0;
    logic [4:0] exp_q[$];
    int exp_stall, exp_flush, exp_freeze;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic check_counts(input string name);
        check({name, " stall_count"},  stall_cnt,  32'(exp_stall));
        check({name, " flush_count"},  flush_cnt,  32'(exp_flush));
        check({name, " freeze_count"}, freeze_cnt, 32'(exp_freeze));
        check({name, " stall_count4"}, 32'(stall_cnt4), sat4(exp_stall));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic rdir, input logic busy);
        mem_read = mr;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        redirect = rdir;
        mem_busy = busy;
    endtask

    // One cycle: inputs already driven; check enables mid-cycle, then the
    // registered state after the edge, and update the counter model.
    task automatic step(input string name, input logic [4:0] exp_o, input logic [1:0] exp_s);
        logic [4:0] e;
        exp_q.push_back(exp_o);
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, " enables"}, 32'(outs), 32'(e));
        @(posedge clk);
        #1;
        check({name, " state"}, 32'(state), 32'(exp_s));
        case (exp_s)
            S_STALL:  exp_stall++;
            S_FLUSH:  exp_flush++;
            S_FREEZE: exp_freeze++;
            default:  ;
        endcase
    endtask

    // Assert reset for one rising edge; leaves the bench 1 unit after an edge.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        exp_stall  = 0;
        exp_flush  = 0;
        exp_freeze = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rdir;
        logic       busy;
        logic [4:0] exp_o;
        logic [1:0] exp_s;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"idle",             1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, O_RUN,    S_RUN};
        vecs[1]  = '{"load_use_rs2",     1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b0, O_STALL,  S_STALL};
        vecs[2]  = '{"load_use_rs1",     1'b1, 5'd7,  5'd7, 5'd3,  1'b0, 1'b0, O_STALL,  S_STALL};
        vecs[3]  = '{"load_x0",          1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, O_RUN,    S_RUN};
        vecs[4]  = '{"no_load",          1'b0, 5'd5,  5'd5, 5'd5,  1'b0, 1'b0, O_RUN,    S_RUN};
        vecs[5]  = '{"load_no_match",    1'b1, 5'd5,  5'd6, 5'd4,  1'b0, 1'b0, O_RUN,    S_RUN};
        vecs[6]  = '{"redir_and_lu",     1'b1, 5'd9,  5'd9, 5'd1,  1'b1, 1'b0, O_FLUSH,  S_FLUSH};
        vecs[7]  = '{"redir_only",       1'b0, 5'd0,  5'd1, 5'd2,  1'b1, 1'b0, O_FLUSH,  S_FLUSH};
        vecs[8]  = '{"busy_only",        1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, O_FREEZE, S_FREEZE};
        vecs[9]  = '{"busy_and_lu",      1'b1, 5'd31, 5'd2, 5'd31, 1'b0, 1'b1, O_FREEZE, S_FREEZE};
        vecs[10] = '{"idle_after",       1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, O_RUN,    S_RUN};
    end

    // ---------------- test ----------------
    initial begin
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
        exp_stall  = 0;
        exp_flush  = 0;
        exp_freeze = 0;

        // Reset state: outputs forced low even with hazard inputs present.
        #3;
        check("reset enables", 32'(outs), 32'(O_FREEZE));
        check("reset state", 32'(state), 32'(S_RUN));
        check_counts("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single-cycle vectors, each independent of the previous one.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].rdir, vecs[i].busy);
            step(vecs[i].name, vecs[i].exp_o, vecs[i].exp_s);
            check_counts(vecs[i].name);
        end

        // Back-to-back load-use: the bubble clears mem_read, so one stall each.
        apply_reset();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0); step("b2b lu1",    O_STALL, S_STALL);
        drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0); step("b2b bubble", O_RUN,   S_RUN);
        drive(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0); step("b2b lu2",    O_STALL, S_STALL);
        drive(1'b0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0); step("b2b bubble2",O_RUN,   S_RUN);
        check_counts("b2b");

        // Redirect during a 3-cycle freeze replays as exactly one flush.
        apply_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); step("frz1",       O_FREEZE, S_FREEZE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); step("frz2",       O_FREEZE, S_FREEZE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); step("frz3",       O_FREEZE, S_FREEZE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step("frz flush",  O_FLUSH,  S_FLUSH);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step("frz after",  O_RUN,    S_RUN);
        check_counts("frz");
        check("frz freeze_count=3", freeze_cnt, 32'd3);
        check("frz flush_count=1",  flush_cnt,  32'd1);

        // Reset pulsed between edges mid-freeze drops the pending redirect.
        apply_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); step("rst frz1", O_FREEZE, S_FREEZE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); step("rst frz2", O_FREEZE, S_FREEZE);
        #2;
        reset = 1'b0;
        #1;
        exp_stall  = 0;
        exp_flush  = 0;
        exp_freeze = 0;
        check("async reset state", 32'(state), 32'(S_RUN));
        check_counts("async reset");
        #1;
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("rst no flush", O_RUN, S_RUN);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("rst no flush2", O_RUN, S_RUN);
        check_counts("rst after");

        // Saturation: 20 stall cycles; 4-bit counter must stop at 15.
        apply_reset();
        drive(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("sat stall", O_STALL, S_STALL);
        end
        check_counts("sat");
        check("sat stall_count4=15", 32'(stall_cnt4), 32'd15);
        check("sat stall_count=20",  stall_cnt,        32'd20);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad_checks);
        $fatal(1, "timeout");
    end

endmodule
